// File: rtl/demux4_rr_dispatcher.sv
// Round-robin dispatcher driving the select of a 1-to-4 demux.
// One held word is steered to the next enabled channel and kept until that consumer takes it.
module demux4_rr_dispatcher #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [3:0]        chan_en,
  output logic [3:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic [3:0]        out_ready,
  output logic [1:0]        sel,
  output logic              busy,
  output logic [15:0]       xfer_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state, state_next;
  logic [1:0]        ptr, ptr_next;
  logic [1:0]        sel_next;
  logic [1:0]        base;
  logic [1:0]        target;
  logic [DATA_W-1:0] data_next;
  logic [15:0]       cnt_next;
  logic [3:0]        valid_next;
  logic              accept;
  logic              xfer;

  assign in_ready = (|chan_en) && ((state == IDLE) || out_ready[sel]);
  assign xfer     = (state == SEND) && out_ready[sel];
  assign accept   = in_valid && in_ready;
  assign busy     = (state == SEND);

  // Input can only be accepted in SEND together with a transfer, so the search then resumes after sel.
  assign base = (state == SEND) ? sel + 2'd1 : ptr;

  // Descending scan so the smallest enabled offset from base wins.
  always_comb begin
    target = base;
    for (int k = 3; k >= 0; k--) begin
      if (chan_en[base + 2'(k)]) begin
        target = base + 2'(k);
      end
    end
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    sel_next   = sel;
    data_next  = out_data;
    cnt_next   = xfer_cnt;
    valid_next = out_valid;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SEND;
          sel_next   = target;
          data_next  = in_data;
        end
      end
      SEND: begin
        if (xfer) begin
          cnt_next = xfer_cnt + 16'd1;
          if (accept) begin
            sel_next  = target;
            data_next = in_data;
          end else begin
            ptr_next   = sel + 2'd1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    valid_next = (state_next == SEND) ? (4'b0001 << sel_next) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      sel       <= 2'd0;
      out_data  <= '0;
      out_valid <= 4'b0000;
      xfer_cnt  <= 16'd0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      sel       <= sel_next;
      out_data  <= data_next;
      out_valid <= valid_next;
      xfer_cnt  <= cnt_next;
    end
  end

endmodule

// File: tb/tb_demux4_rr_dispatcher.sv
// Directed bench for demux4_rr_dispatcher: a queue-based reference model checked every cycle,
// plus hand-computed delivery sequences and boundary checks.
module tb_demux4_rr_dispatcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [3:0]  chan_en = 4'b1111;
  logic [3:0]  out_valid;
  logic [7:0]  out_data;
  logic [3:0]  out_ready = 4'b0000;
  logic [1:0]  sel;
  logic        busy;
  logic [15:0] xfer_cnt;

  int n_checks = 0;
  int n_errors = 0;

  demux4_rr_dispatcher #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .chan_en(chan_en), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .sel(sel), .busy(busy),
    .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         chan;
    logic [7:0] data;
  } word_t;

  // Reference model: at most one pending word, delivered to the first enabled channel in rotation.
  word_t       held_q[$];
  int          m_ptr = 0;
  int          m_sel = 0;
  logic [7:0]  m_data = 8'h00;
  logic [15:0] m_cnt = 16'h0000;
  word_t       m_done;
  word_t       m_new;
  bit          m_xf, m_ac;
  int          m_base;

  function automatic int pick(int base, logic [3:0] mask);
    for (int k = 0; k < 4; k++) begin
      if (mask[(base + k) % 4]) return (base + k) % 4;
    end
    return 0;
  endfunction

  function automatic bit exp_ready();
    if (chan_en == 4'b0000) return 1'b0;
    if (held_q.size() == 0) return 1'b1;
    return out_ready[held_q[0].chan];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q.delete();
      m_ptr  = 0;
      m_sel  = 0;
      m_data = 8'h00;
      m_cnt  = 16'h0000;
    end else begin
      m_ac = in_valid && exp_ready();
      m_xf = (held_q.size() != 0) && out_ready[held_q[0].chan];
      if (m_xf) begin
        m_done = held_q.pop_front();
        m_cnt  = m_cnt + 16'd1;
        if (!m_ac) m_ptr = (m_done.chan + 1) % 4;
      end
      if (m_ac) begin
        m_base     = m_xf ? (m_done.chan + 1) % 4 : m_ptr;
        m_new.chan = pick(m_base, chan_en);
        m_new.data = in_data;
        held_q.push_back(m_new);
        m_sel  = m_new.chan;
        m_data = in_data;
      end
    end
  end

  task automatic checkOutput(string name, int actual, int expected);
    n_checks++;
    if (actual != expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model, sampled on the inactive edge.
  always @(negedge clk) begin
    checkOutput("out_valid", int'(out_valid),
                (held_q.size() != 0) ? (1 << held_q[0].chan) : 0);
    checkOutput("out_data", int'(out_data), int'(m_data));
    checkOutput("sel", int'(sel), m_sel);
    checkOutput("busy", int'(busy), (held_q.size() != 0) ? 1 : 0);
    checkOutput("xfer_cnt", int'(xfer_cnt), int'(m_cnt));
    checkOutput("in_ready", int'(in_ready), int'(exp_ready()));
  end

  // Delivery log taken from the DUT pins mid-cycle, for the hand-computed sequences.
  int         log_chan[$];
  logic [7:0] log_data[$];

  always begin
    @(negedge clk);
    #3;
    if (rst_n && ((out_valid & out_ready) != 4'b0000)) begin
      log_chan.push_back(int'(sel));
      log_data.push_back(out_data);
    end
  end

  task automatic applyStimulus(bit v, logic [7:0] d, logic [3:0] en, logic [3:0] ordy);
    @(negedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    chan_en   = en;
    out_ready = ordy;
  endtask

  task automatic clearLog();
    log_chan.delete();
    log_data.delete();
  endtask

  task automatic checkLog(string name, int idx, int exp_chan, int exp_data);
    checkOutput({name, "_chan"}, (log_chan.size() > idx) ? log_chan[idx] : -1, exp_chan);
    checkOutput({name, "_data"}, (log_data.size() > idx) ? int'(log_data[idx]) : -1, exp_data);
  endtask

  int guard;

  initial begin
    #1 rst_n = 1'b0;
    applyStimulus(0, 8'h00, 4'b1111, 4'b0000);
    applyStimulus(0, 8'h00, 4'b1111, 4'b0000);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_sel", int'(sel), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_xfer_cnt", int'(xfer_cnt), 0);
    checkOutput("rst_in_ready", int'(in_ready), 1);

    // Back-to-back stream with every channel enabled and ready.
    clearLog();
    for (int i = 0; i < 8; i++) applyStimulus(1, 8'hA0 + 8'(i), 4'b1111, 4'b1111);
    applyStimulus(0, 8'h00, 4'b1111, 4'b1111);
    applyStimulus(0, 8'h00, 4'b1111, 4'b1111);
    #1;
    checkOutput("stream_cnt", int'(xfer_cnt), 8);
    for (int i = 0; i < 8; i++) checkLog("stream", i, i % 4, 'hA0 + i);

    // Sparse mask skips disabled channels.
    clearLog();
    for (int i = 0; i < 4; i++) applyStimulus(1, 8'h11 + 8'(i), 4'b1010, 4'b1111);
    applyStimulus(0, 8'h00, 4'b1010, 4'b1111);
    applyStimulus(0, 8'h00, 4'b1010, 4'b1111);
    checkLog("mask1010", 0, 1, 'h11);
    checkLog("mask1010", 1, 3, 'h12);
    checkLog("mask1010", 2, 1, 'h13);
    checkLog("mask1010", 3, 3, 'h14);

    clearLog();
    applyStimulus(1, 8'h15, 4'b0100, 4'b1111);
    applyStimulus(0, 8'h00, 4'b0100, 4'b1111);
    applyStimulus(0, 8'h00, 4'b0100, 4'b1111);
    checkLog("mask0100", 0, 2, 'h15);

    // Stalled channel 0 holds the word and blocks the input.
    applyStimulus(1, 8'h55, 4'b0001, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 8'h66, 4'b0001, 4'b0000);
      #1;
      checkOutput("stall_out_valid", int'(out_valid), 'b0001);
      checkOutput("stall_out_data", int'(out_data), 'h55);
      checkOutput("stall_in_ready", int'(in_ready), 0);
    end
    clearLog();
    applyStimulus(1, 8'h66, 4'b1111, 4'b1111);
    applyStimulus(0, 8'h00, 4'b1111, 4'b1111);
    #1;
    checkOutput("after_stall_sel", int'(sel), 1);
    applyStimulus(0, 8'h00, 4'b1111, 4'b1111);
    checkLog("stall", 0, 0, 'h55);
    checkLog("stall", 1, 1, 'h66);

    // No channel enabled: nothing accepted.
    applyStimulus(1, 8'h77, 4'b0000, 4'b1111);
    #1;
    checkOutput("noen_in_ready", int'(in_ready), 0);
    applyStimulus(1, 8'h77, 4'b0000, 4'b1111);
    #1;
    checkOutput("noen_busy", int'(busy), 0);

    // Counter wrap through a long sustained stream.
    guard = 0;
    forever begin
      applyStimulus(1, 8'(guard), 4'b1111, 4'b1111);
      guard++;
      if (m_cnt == 16'hFFFF || guard > 70000) break;
    end
    checkOutput("wrap_guard", (guard > 70000) ? 1 : 0, 0);
    #1;
    checkOutput("wrap_ffff", int'(xfer_cnt), 'hFFFF);
    applyStimulus(0, 8'h00, 4'b1111, 4'b1111);
    #1;
    checkOutput("wrap_zero", int'(xfer_cnt), 0);
    applyStimulus(0, 8'h00, 4'b1111, 4'b1111);

    // Asynchronous reset while holding a word for channel 2.
    applyStimulus(1, 8'h99, 4'b0100, 4'b0000);
    applyStimulus(0, 8'h00, 4'b0100, 4'b0000);
    #1;
    checkOutput("pre_rst_busy", int'(busy), 1);
    checkOutput("pre_rst_sel", int'(sel), 2);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", int'(out_valid), 0);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_sel", int'(sel), 0);
    checkOutput("mid_rst_out_data", int'(out_data), 0);
    checkOutput("mid_rst_in_ready", int'(in_ready), 1);
    applyStimulus(0, 8'h00, 4'b1111, 4'b1111);
    clearLog();
    applyStimulus(1, 8'hAB, 4'b1111, 4'b1111);
    rst_n = 1'b1;
    applyStimulus(0, 8'h00, 4'b1111, 4'b1111);
    applyStimulus(0, 8'h00, 4'b1111, 4'b1111);
    checkLog("post_rst", 0, 0, 'hAB);
    checkOutput("post_rst_count", log_chan.size(), 1);

    applyStimulus(0, 8'h00, 4'b1111, 4'b0000);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demux4_rr_dispatcher.md
# demux4_rr_dispatcher

Round-robin dispatcher that sequences the select lines of the 1-to-4 demultiplexer. It accepts a single valid/ready input stream and steers each word to exactly one of four consumer channels in rotation, skipping disabled channels. Each word is held until the chosen consumer accepts it. The block owns the demux select: `sel` drives the demux `s[1:0]`, and `out_valid` is the demux output pattern qualified by the handshake.

## Interface
- `DATA_W`, 8, width of the data word.

- `clk`  input  1  single clock; all state changes on its rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `in_valid`  input  1  producer has a word on `in_data`.
- `in_data`  input  DATA_W  input word.
- `in_ready`  output  1  dispatcher accepts `in_data` this cycle.
- `chan_en`  input  4  per-channel enable; bit i set = channel i may receive words.
- `out_valid`  output  4  one-hot (or zero); bit i = word on `out_data` is for channel i.
- `out_data`  output  DATA_W  held word, shared by all channels.
- `out_ready`  input  4  per-channel consumer ready.
- `sel`  output  2  current target channel; drives demux select.
- `busy`  output  1  a word is held (state SEND).
- `xfer_cnt`  output  16  count of completed output transfers, wraps.

## Operation
- States: IDLE (no word held) and SEND (word held for channel `sel`). A 2-bit pointer `ptr` holds the next channel to try.
- Input accept: `in_valid && in_ready`.
- Output transfer: `out_valid[sel] && out_ready[sel]`.
- Target search order: start at the base channel, then base+1, base+2, base+3 (mod 4). Pick the first channel whose `chan_en` bit is set.
  - The base is `ptr` in IDLE.
  - The base is `sel+1` (mod 4) when a new word is accepted in the same cycle as an output transfer.
- `in_ready` is high when `|chan_en` and either:
  - the state is IDLE, or
  - the state is SEND and `out_ready[sel]` is high.
- In IDLE, on accept: latch `in_data` into `out_data`, set `sel` to the target, go to SEND.
- In SEND:
  - Drive `out_valid` = one-hot(`sel`); all other bits are 0.
  - On transfer with no accept: `ptr <= sel+1`, go to IDLE.
  - On transfer with a simultaneous accept: latch the new word and new target, stay in SEND. This gives one word per cycle throughput.
- `xfer_cnt` increments by 1 on every output transfer, wrapping 0xFFFF -> 0x0000.
- `busy` = (state == SEND).
- Boundary conditions:
  - All `chan_en` = 0: `in_ready` = 0. A held word still completes to its committed channel.
  - `chan_en` changing while in SEND: the held word is not retargeted. The new mask applies only to the next search.
  - `out_ready` on non-selected channels is ignored.
  - `out_data` and `sel` are stable while `out_valid` is high and not accepted.
  - Reset asserted mid-SEND: the held word is discarded and every output goes immediately to its reset value.
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `sel` = 0.
  - `busy` = 0, `xfer_cnt` = 0.
  - Internal: `ptr` = 0, state IDLE.
  - `in_ready` follows its equation: 1 if `|chan_en`.

## Timing
- Latency: a word accepted at edge N drives `out_valid` from edge N through its transfer edge. It is visible the cycle after acceptance, with no combinational path from `in_data` to `out_data`.
- `in_ready` is combinational from state, `out_ready[sel]` and `chan_en`. `out_valid`, `out_data` and `sel` are registered.
- Sustained throughput is 1 word/cycle when targets are always ready.
- Bubble cases:
  - Transfer with no pending input leaves one idle cycle (IDLE).
  - A stalled target blocks the input. There is no bypass to other channels.

## Test plan
- Reset, then `rst_n` deasserted with `chan_en` = 4'b1111 -> `out_valid` = 0, `sel` = 0, `busy` = 0, `xfer_cnt` = 0, `in_ready` = 1.
- All enabled, `out_ready` = 4'b1111, inputs 0xA0..0xA7 back-to-back -> delivered on channels 0,1,2,3,0,1,2,3, one per cycle, with data in order; `xfer_cnt` = 8.
- `chan_en` = 4'b1010, four words 0x11..0x14 -> channels 1,3,1,3.
- Then `chan_en` = 4'b0100 -> next word goes to channel 2.
- Backpressure: target channel 0 with `out_ready[0]` = 0 for 5 cycles -> `out_valid` = 4'b0001 held, `out_data` stable, `in_ready` = 0. Raise `out_ready[0]` -> transfer; next word goes to channel 1.
- `chan_en` = 0 with `in_valid` high -> `in_ready` = 0 and no acceptance.
- Preload `xfer_cnt` to 0xFFFF via 65535 transfers, then 1 more transfer -> `xfer_cnt` = 0x0000.
- Drop `rst_n` while `busy` = 1 on channel 2 -> `out_valid` = 0 and `busy` = 0 immediately. After release, the first word goes to channel 0.
